// File: rtl/logit_collector_if.sv
// ============================================================================
//  Module      : logit_collector_if
//  Description : Stream-in / frame-out bundle for logit_collector.
//                Upstream logit stream plus the parallel score frame with
//                its acknowledge, error pulse and good-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface logit_collector_if #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 32
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] scores [N_CLASSES];
  logic              scores_valid;
  logic              scores_ack;
  logic              frame_err;
  logic [15:0]       frame_cnt;

  // Producer / consumer side (testbench or surrounding datapath)
  modport master (
    output in_data, in_valid, in_last, scores_ack,
    input  in_ready, scores, scores_valid, frame_err, frame_cnt
  );

  // Collector side
  modport slave (
    input  in_data, in_valid, in_last, scores_ack,
    output in_ready, scores, scores_valid, frame_err, frame_cnt
  );

endinterface

`default_nettype wire

// File: rtl/logit_collector.sv
// ============================================================================
//  Module      : logit_collector
//  Description : Collects N_CLASSES FP32 logits from a valid/ready stream
//                into a register array, presents the frame in parallel
//                until acknowledged, and flags short/long frames.
//  Options     : LOGIT_SIGN_CLAMP_EN - store negative finite logits as +0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module logit_collector #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 4
) (
  input  wire logic        Clk,
  input  wire logic        Reset_n,
  logit_collector_if.slave bus
);

  localparam logic [1:0]       c_ST_FILL  = 2'd0;
  localparam logic [1:0]       c_ST_HOLD  = 2'd1;
  localparam logic [1:0]       c_ST_DRAIN = 2'd2;
  localparam logic [CNT_W-1:0] c_IDX_LAST = CNT_W'(N_CLASSES - 1);
  localparam logic [CNT_W-1:0] c_IDX_ONE  = CNT_W'(1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_scores [N_CLASSES];
  logic              r_frame_err;
  logic [15:0]       r_frame_cnt;

  logic              w_in_ready;
  logic              w_xfer;
  logic              w_idx_last;
  logic [DATA_W-1:0] w_data;

  assign w_in_ready = (r_state != c_ST_HOLD);
  assign w_xfer     = bus.in_valid & w_in_ready;
  assign w_idx_last = (r_idx == c_IDX_LAST);

`ifdef LOGIT_SIGN_CLAMP_EN
  // Negative finite values (incl. -0) become +0 so the downstream
  // magnitude compare cannot rank them; NaN/Inf (exponent all ones) pass.
  logic w_is_special;
  assign w_is_special = &bus.in_data[DATA_W-2 -: 8];
  assign w_data = (bus.in_data[DATA_W-1] && !w_is_special) ? '0 : bus.in_data;
`else
  assign w_data = bus.in_data;
`endif

  // Frame-assembly FSM: index, error pulse and good-frame counter
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= c_ST_FILL;
      r_idx       <= '0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        c_ST_FILL: begin
          if (w_xfer) begin
            if (bus.in_last) begin
              r_idx <= '0;
              if (w_idx_last) begin
                r_state     <= c_ST_HOLD;
                r_frame_cnt <= r_frame_cnt + 16'd1;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else if (w_idx_last) begin
              // Frame overflowed without in_last: report once, then skip to it
              r_frame_err <= 1'b1;
              r_idx       <= '0;
              r_state     <= c_ST_DRAIN;
            end else begin
              r_idx <= r_idx + c_IDX_ONE;
            end
          end
        end
        c_ST_DRAIN: begin
          if (w_xfer && bus.in_last) begin
            r_state <= c_ST_FILL;
          end
        end
        c_ST_HOLD: begin
          if (bus.scores_ack) begin
            r_state <= c_ST_FILL;
          end
        end
        default: begin
          r_state <= c_ST_FILL;
        end
      endcase
    end
  end

  // Score array: written only while filling, frozen in HOLD and DRAIN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        r_scores[i] <= '0;
      end
    end else if (w_xfer && (r_state == c_ST_FILL)) begin
      r_scores[r_idx] <= w_data;
    end
  end

  generate
    for (genvar g = 0; g < N_CLASSES; g++) begin : g_scores
      assign bus.scores[g] = r_scores[g];
    end
  endgenerate

  assign bus.in_ready     = w_in_ready;
  assign bus.scores_valid = (r_state == c_ST_HOLD);
  assign bus.frame_err    = r_frame_err;
  assign bus.frame_cnt    = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_logit_collector.sv
// ============================================================================
//  Module      : tb_logit_collector
//  Description : Scoreboard bench for logit_collector. A frame-level model
//                turns accepted logits into expected events (good frame or
//                error); a monitor compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logit_collector;

  localparam int N  = 10;
  localparam int DW = 32;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logit_collector_if #(.N_CLASSES(N), .DATA_W(DW)) bus ();

  logit_collector #(.N_CLASSES(N), .DATA_W(DW), .CNT_W(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Expected-event scoreboard (one entry per event, parallel queues)
  bit              exp_is_err [$];
  logic [N*DW-1:0] exp_frame  [$];
  logic [15:0]     exp_cnt    [$];

  // Frame-level reference model
  logic [DW-1:0] m_frame [$];
  bit            m_hold;
  bit            m_drain;
  logic [15:0]   m_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_rst = 1'b0;
  bit mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (N*DW > 64)
        $display("FAIL %s: got %0h expected %0h", nm, act[63:0], exp[63:0]);
      else
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_store(input logic [DW-1:0] x);
`ifdef LOGIT_SIGN_CLAMP_EN
    if (x[31] && (x[30:23] != 8'hFF)) return '0;
`endif
    return x;
  endfunction

  // Spec rules at frame granularity: count logits, decide on in_last
  task automatic model_xfer(input logic [DW-1:0] d, input bit l);
    logic [N*DW-1:0] fr;
    if (m_drain) begin
      if (l) m_drain = 1'b0;
      return;
    end
    m_frame.push_back(model_store(d));
    if (l) begin
      if (m_frame.size() == N) begin
        for (int i = 0; i < N; i++) fr[i*DW +: DW] = m_frame[i];
        m_cnt = m_cnt + 16'd1;
        exp_is_err.push_back(1'b0);
        exp_frame.push_back(fr);
        exp_cnt.push_back(m_cnt);
        m_hold = 1'b1;
      end else begin
        exp_is_err.push_back(1'b1);
        exp_frame.push_back('0);
        exp_cnt.push_back(m_cnt);
      end
      m_frame.delete();
    end else if (m_frame.size() == N) begin
      exp_is_err.push_back(1'b1);
      exp_frame.push_back('0);
      exp_cnt.push_back(m_cnt);
      m_drain = 1'b1;
      m_frame.delete();
    end
  endtask

  // One clock of stimulus; inputs change on the falling edge
  task automatic step(input bit v, input logic [DW-1:0] d, input bit l,
                      input bit a, input bit rn, output bit acc);
    @(negedge Clk);
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_last    = l;
    bus.scores_ack = a;
    Reset_n        = rn;
    acc            = 1'b0;
    if (!rn) begin
      m_frame.delete();
      m_hold  = 1'b0;
      m_drain = 1'b0;
      m_cnt   = '0;
      chk_rst = 1'b1;
    end else begin
      chk("in_ready", {{(N*DW-1){1'b0}}, bus.in_ready}, {{(N*DW-1){1'b0}}, !m_hold});
      chk("scores_valid_level", {{(N*DW-1){1'b0}}, bus.scores_valid}, {{(N*DW-1){1'b0}}, m_hold});
      if (v && bus.in_ready) begin
        acc = 1'b1;
        model_xfer(d, l);
      end else if (m_hold && a) begin
        m_hold = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit l);
    bit acc;
    step(1'b1, d, l, 1'b0, 1'b1, acc);
  endtask

  task automatic idle(input int n, input bit a);
    bit acc;
    repeat (n) step(1'b0, $urandom, 1'b0, a, 1'b1, acc);
  endtask

  // Valid traffic while the frame is held; none of it may be accepted
  task automatic hold_noise(input int n);
    bit acc;
    repeat (n) step(1'b1, $urandom, 1'($urandom % 2), 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic good_frame(input logic [DW-1:0] base);
    for (int k = 0; k < N; k++) send(base + DW'(k), k == N-1);
  endtask

  // Monitor: each edge produces at most the event pushed for that edge
  initial begin : mon
    logic [N*DW-1:0] cur;
    logic [N*DW-1:0] snap;
    bit              prev_sv;
    bit              want_err;
    bit              want_rise;
    prev_sv = 1'b0;
    snap    = '0;
    wait (mon_en);
    forever begin
      @(posedge Clk);
      #1;
      for (int i = 0; i < N; i++) cur[i*DW +: DW] = bus.scores[i];
      if (chk_rst) begin
        chk_rst = 1'b0;
        chk("rst_scores",    cur, '0);
        chk("rst_frame_cnt", {{(N*DW-16){1'b0}}, bus.frame_cnt}, '0);
        chk("rst_in_ready",  {{(N*DW-1){1'b0}}, bus.in_ready}, 1);
      end
      want_err  = (exp_is_err.size() > 0) && exp_is_err[0];
      want_rise = (exp_is_err.size() > 0) && !exp_is_err[0];
      chk("frame_err", {{(N*DW-1){1'b0}}, bus.frame_err}, {{(N*DW-1){1'b0}}, want_err});
      chk("scores_valid_rise", {{(N*DW-1){1'b0}}, bus.scores_valid && !prev_sv},
          {{(N*DW-1){1'b0}}, want_rise});
      if (want_rise) begin
        chk("scores", cur, exp_frame[0]);
        chk("frame_cnt", {{(N*DW-16){1'b0}}, bus.frame_cnt}, {{(N*DW-16){1'b0}}, exp_cnt[0]});
        snap = cur;
      end else if (bus.scores_valid && prev_sv) begin
        chk("scores_stable", cur, snap);
      end
      if (exp_is_err.size() > 0) begin
        void'(exp_is_err.pop_front());
        void'(exp_frame.pop_front());
        void'(exp_cnt.pop_front());
      end
      prev_sv = bus.scores_valid;
    end
  end

  initial begin : drv
    bit          acc;
    bit          v, l, a, rn;
    logic [DW-1:0] d;
    int          tgt, sent, got;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.scores_ack = 1'b0;

    do_reset(2);
    mon_en = 1'b1;

    // Basic frame, held 20 cycles with input noise, then released
    good_frame(32'h3F80_0000);
    hold_noise(20);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Short frame followed by a good frame
    do_reset(1);
    for (int k = 0; k < 4; k++) send(32'h4000_0000 + DW'(k), k == 3);
    idle(2, 1'b1);
    good_frame(32'h4100_0000);
    idle(2, 1'b0);
    idle(1, 1'b1);

    // Long frame: 13 logits, in_last on the 13th
    for (int k = 0; k < 13; k++) send(32'h4200_0000 + DW'(k), k == 12);
    idle(3, 1'b1);

    // Negative logit at k=3 (clamped only when the option is built in)
    for (int k = 0; k < N; k++)
      send((k == 3) ? 32'hC2C8_0000 : 32'h3F80_0000 + DW'(k), k == N-1);
    idle(2, 1'b0);
    idle(1, 1'b1);

    // Bubbles during fill, then the next frame overwrites
    got = 0;
    while (got < N) begin
      v = ($urandom % 2) != 0;
      step(v, 32'h4300_0000 + DW'(got), got == N-1, 1'b0, 1'b1, acc);
      if (acc) got++;
    end
    hold_noise(20);
    idle(1, 1'b1);
    good_frame(32'h4400_0000);
    idle(1, 1'b1);

    // Reset at index 6, and again while holding
    for (int k = 0; k < 6; k++) send(32'h4500_0000 + DW'(k), 1'b0);
    do_reset(1);
    good_frame(32'h4600_0000);
    idle(3, 1'b0);
    do_reset(1);
    good_frame(32'h4700_0000);
    idle(1, 1'b1);

    // Randomized traffic: mixed frame lengths, acks and occasional resets
    tgt  = 10;
    sent = 0;
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom % 4) != 0;
      rn = ($urandom % 400) != 0;
      a  = ($urandom % 6) == 0;
      l  = (sent == tgt - 1);
      d  = $urandom;
      if ($urandom % 4 == 0) d[31] = 1'b1;
      step(v, d, l, a, rn, acc);
      if (!rn) begin
        sent = 0;
      end else if (acc) begin
        if (l) begin
          sent = 0;
          tgt  = ($urandom % 3 == 0) ? int'($urandom_range(1, 13)) : 10;
        end else begin
          sent++;
        end
      end
    end
    idle(3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
